// File: rtl/user_fpga_test_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_fpga_test_core_pkg
// Description : Shared types and constants for the template-matching core.
// Revision    : 1.0 - initial release
// ============================================================================
package user_fpga_test_core_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_TPL = 3'd1,
        LOAD_WIN = 3'd2,
        SCORE    = 3'd3,
        WRITE    = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int INT_W  = 10;
    localparam int FRAC_W = 54;

    // Signed fixed point, bit range [9:-54]
    typedef logic signed [INT_W+FRAC_W-1:0] score_t;

    localparam score_t     SCORE_MIN  = 64'sh8000_0000_0000_0000;
    localparam logic [6:0] WB_ROW     = 7'd127;
    localparam logic [6:0] WB_COL     = 7'd127;
    localparam logic       WB_TEM_WIN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/user_fpga_test_core_log2_approx.sv
`default_nettype none
// ============================================================================
// Module      : log2_approx
// Description : Piecewise-linear log2: integer part = MSB position, fraction =
//               the bits below the MSB left-aligned (truncated).
// Revision    : 1.0 - initial release
// ============================================================================
module log2_approx
    import user_fpga_test_core_pkg::*;
#(
    parameter int WIDTH = 22
) (
    input  logic [WIDTH-1:0] x,
    output logic             is_zero,
    output score_t           log2_x
);

    localparam int POS_W = $clog2(WIDTH);

    logic [POS_W-1:0] w_msb_pos;
    logic [WIDTH-2:0] w_below;
    logic [FRAC_W-1:0] w_frac;

    always_comb begin
        w_msb_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                w_msb_pos = POS_W'(i);
            end
        end
    end

    // The MSB itself only ever lands at bit WIDTH-1, so shifting the lower bits suffices
    assign w_below = x[WIDTH-2:0] << (POS_W'(WIDTH-1) - w_msb_pos);
    assign w_frac  = {w_below, {(FRAC_W-WIDTH+1){1'b0}}};
    assign is_zero = (x == '0);
    assign log2_x  = {INT_W'(w_msb_pos), w_frac};

endmodule
`default_nettype wire

// File: rtl/user_fpga_test_core.sv
`default_nettype none
// ============================================================================
// Module      : user_fpga_test_core
// Description : Loads a template, scores every non-overlapping image tile with
//               a log-domain NCC approximation, and writes back the best index.
// Revision    : 1.0 - initial release
// ============================================================================
module user_fpga_test_core
    import user_fpga_test_core_pkg::*;
#(
    parameter int TPL_N = 8,
    parameter int IMG_N = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ready_2_start,
    input  logic [31:0] read_data,
    output logic        req,
    output logic        rd_wr,
    output logic [31:0] write_data,
    output logic [6:0]  row,
    output logic [6:0]  col,
    output logic        tem_win,
    output logic        set_done,
    output logic [63:0] greatestNCCLog2,
    output logic [8:0]  greatestWindowIndex
);

    localparam int TPL_PIX = TPL_N * TPL_N;
    localparam int PIX_W   = (TPL_PIX > 1) ? $clog2(TPL_PIX) : 1;
    localparam int TILES   = IMG_N / TPL_N;
    localparam int ACC_W   = (16 + PIX_W > 22) ? 16 + PIX_W : 22;
    localparam int IDX_W   = 9;
    localparam int CRD_W   = 7;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CRD_W-1:0]   prow_q, prow_d, pcol_q, pcol_d;
    logic [CRD_W-1:0]   trow_q, trow_d, tcol_q, tcol_d;
    logic [ACC_W-1:0]   et_q, et_d, c_q, c_d, ew_q, ew_d;
    score_t             best_q, best_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [CRD_W-1:0]   row_q, row_d, col_q, col_d;
    logic               tem_win_q, tem_win_d;
    logic [7:0]         tpl_mem_q [TPL_PIX];

    logic               w_tpl_we;
    logic [7:0]         w_pix, w_tpl_pix;
    logic               w_unused_hi;
    logic [PIX_W-1:0]   w_pidx;
    logic [15:0]        w_sq, w_tw;
    logic               w_last_col, w_last_pix, w_last_tile_col, w_last_tile;
    logic [CRD_W-1:0]   w_pcol_nxt, w_prow_nxt;
    logic [CRD_W-1:0]   w_win_row, w_win_col;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_zc, w_zt, w_zw;
    score_t             w_log_c, w_log_t, w_log_w, w_score;

    assign w_pix       = read_data[7:0];
    assign w_unused_hi = ^read_data[31:8];
    assign w_pidx      = PIX_W'(prow_q) * PIX_W'(TPL_N) + PIX_W'(pcol_q);
    assign w_tpl_pix   = tpl_mem_q[w_pidx];
    assign w_sq        = 16'(w_pix) * 16'(w_pix);
    assign w_tw        = 16'(w_tpl_pix) * 16'(w_pix);

    assign w_last_col      = (pcol_q == CRD_W'(TPL_N - 1));
    assign w_last_pix      = w_last_col && (prow_q == CRD_W'(TPL_N - 1));
    assign w_last_tile_col = (tcol_q == CRD_W'(TILES - 1));
    assign w_last_tile     = w_last_tile_col && (trow_q == CRD_W'(TILES - 1));
    assign w_pcol_nxt      = w_last_col ? '0 : pcol_q + 1'b1;
    assign w_prow_nxt      = w_last_pix ? '0 : (w_last_col ? prow_q + 1'b1 : prow_q);

    assign w_win_row = trow_q * CRD_W'(TPL_N) + prow_q;
    assign w_win_col = tcol_q * CRD_W'(TPL_N) + pcol_q;
    assign w_win_idx = IDX_W'(trow_q) * IDX_W'(TILES) + IDX_W'(tcol_q);

    log2_approx #(.WIDTH(ACC_W)) u_log_c (.x(c_q),  .is_zero(w_zc), .log2_x(w_log_c));
    log2_approx #(.WIDTH(ACC_W)) u_log_t (.x(et_q), .is_zero(w_zt), .log2_x(w_log_t));
    log2_approx #(.WIDTH(ACC_W)) u_log_w (.x(ew_q), .is_zero(w_zw), .log2_x(w_log_w));

    assign w_score = (w_zc || w_zt || w_zw) ? SCORE_MIN
                                            : (w_log_c <<< 1) - w_log_t - w_log_w;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        prow_d     = prow_q;
        pcol_d     = pcol_q;
        trow_d     = trow_q;
        tcol_d     = tcol_q;
        et_d       = et_q;
        c_d        = c_q;
        ew_d       = ew_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        tem_win_d  = tem_win_q;
        w_tpl_we   = 1'b0;
        req        = 1'b0;
        rd_wr      = 1'b0;
        write_data = '0;

        unique case (state_q)
            IDLE: begin
                if (ready_2_start) begin
                    state_d = LOAD_TPL;
                    phase_d = 1'b0;
                    prow_d  = '0;
                    pcol_d  = '0;
                    trow_d  = '0;
                    tcol_d  = '0;
                end
            end
            LOAD_TPL: begin
                if (!phase_q) begin
                    req       = 1'b1;
                    row_d     = prow_q;
                    col_d     = pcol_q;
                    tem_win_d = 1'b1;
                    phase_d   = 1'b1;
                end else begin
                    w_tpl_we = 1'b1;
                    et_d     = et_q + ACC_W'(w_sq);
                    phase_d  = 1'b0;
                    pcol_d   = w_pcol_nxt;
                    prow_d   = w_prow_nxt;
                    if (w_last_pix) begin
                        state_d = LOAD_WIN;
                    end
                end
            end
            LOAD_WIN: begin
                if (!phase_q) begin
                    req       = 1'b1;
                    row_d     = w_win_row;
                    col_d     = w_win_col;
                    tem_win_d = 1'b0;
                    phase_d   = 1'b1;
                end else begin
                    c_d     = c_q + ACC_W'(w_tw);
                    ew_d    = ew_q + ACC_W'(w_sq);
                    phase_d = 1'b0;
                    pcol_d  = w_pcol_nxt;
                    prow_d  = w_prow_nxt;
                    if (w_last_pix) begin
                        state_d = SCORE;
                    end
                end
            end
            SCORE: begin
                // Strict compare keeps the earlier window on ties
                if (w_score > best_q) begin
                    best_d     = w_score;
                    best_idx_d = w_win_idx;
                end
                if (w_last_tile) begin
                    state_d = WRITE;
                end else begin
                    state_d = LOAD_WIN;
                    c_d     = '0;
                    ew_d    = '0;
                    tcol_d  = w_last_tile_col ? '0 : tcol_q + 1'b1;
                    trow_d  = w_last_tile_col ? trow_q + 1'b1 : trow_q;
                end
            end
            WRITE: begin
                req        = 1'b1;
                rd_wr      = 1'b1;
                row_d      = WB_ROW;
                col_d      = WB_COL;
                tem_win_d  = WB_TEM_WIN;
                write_data = {23'b0, best_idx_q};
                state_d    = DONE;
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address lines follow the live request and otherwise hold the last one issued
    assign row     = req ? row_d     : row_q;
    assign col     = req ? col_d     : col_q;
    assign tem_win = req ? tem_win_d : tem_win_q;

    assign set_done            = (state_q == DONE);
    assign greatestNCCLog2     = best_q;
    assign greatestWindowIndex = best_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            prow_q     <= '0;
            pcol_q     <= '0;
            trow_q     <= '0;
            tcol_q     <= '0;
            et_q       <= '0;
            c_q        <= '0;
            ew_q       <= '0;
            best_q     <= SCORE_MIN;
            best_idx_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            tem_win_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            prow_q     <= prow_d;
            pcol_q     <= pcol_d;
            trow_q     <= trow_d;
            tcol_q     <= tcol_d;
            et_q       <= et_d;
            c_q        <= c_d;
            ew_q       <= ew_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tem_win_q  <= tem_win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tpl_we) begin
            tpl_mem_q[w_pidx] <= w_pix;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_user_fpga_test_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_fpga_test_core
// Description : Scoreboard bench: memory responder, reference NCC-log2 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_fpga_test_core;
    import user_fpga_test_core_pkg::*;

    localparam int TPL_N   = 4;
    localparam int IMG_N   = 32;
    localparam int TILES   = IMG_N / TPL_N;
    localparam int TPL_PIX = TPL_N * TPL_N;
    localparam int BUDGET  = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready_2_start = 1'b0;
    logic [31:0] read_data = '0;
    logic        req, rd_wr, tem_win, set_done;
    logic [31:0] write_data;
    logic [6:0]  row, col;
    logic [63:0] greatestNCCLog2;
    logic [8:0]  greatestWindowIndex;

    always #5 clk = ~clk;

    user_fpga_test_core #(.TPL_N(TPL_N), .IMG_N(IMG_N)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ready_2_start       (ready_2_start),
        .read_data           (read_data),
        .req                 (req),
        .rd_wr               (rd_wr),
        .write_data          (write_data),
        .row                 (row),
        .col                 (col),
        .tem_win             (tem_win),
        .set_done            (set_done),
        .greatestNCCLog2     (greatestNCCLog2),
        .greatestWindowIndex (greatestWindowIndex)
    );

    typedef struct packed {
        logic [8:0]  idx;
        logic [63:0] score;
    } result_t;

    logic [31:0] tpl_mem [TPL_PIX];
    logic [31:0] img_mem [IMG_N*IMG_N];
    logic [14:0] addr_q [$];
    result_t     exp_q [$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [63:0] model_l(longint unsigned x);
        int p = 0;
        logic [127:0] t;
        while ((x >> (p + 1)) != 0) p++;
        t = 128'(x - (64'd1 << p));
        t = (t << 54) >> p;
        return {10'(p), t[53:0]};
    endfunction

    function automatic logic [63:0] model_score(longint unsigned c, longint unsigned et,
                                                longint unsigned ew);
        if (c == 0 || et == 0 || ew == 0) return 64'h8000_0000_0000_0000;
        return model_l(c) + model_l(c) - model_l(et) - model_l(ew);
    endfunction

    function automatic logic [31:0] mem_word(logic tw, logic [6:0] r, logic [6:0] c);
        if (tw) begin
            if (int'(r) < TPL_N && int'(c) < TPL_N) return tpl_mem[int'(r)*TPL_N + int'(c)];
            return 32'h0;
        end
        return img_mem[int'(r)*IMG_N + int'(c)];
    endfunction

    task automatic fill_tpl(input logic [31:0] v);
        for (int i = 0; i < TPL_PIX; i++) tpl_mem[i] = v;
    endtask

    task automatic fill_img(input logic [31:0] v);
        for (int i = 0; i < IMG_N*IMG_N; i++) img_mem[i] = v;
    endtask

    task automatic apply_reset();
        ready_2_start = 1'b0;
        read_data = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Push the expected read-address stream and the expected final result
    task automatic build_expect();
        longint unsigned et, c, ew;
        logic [63:0] best, s;
        int best_idx, tp, wp, rr, cc;
        addr_q.delete();
        exp_q.delete();
        et = 0;
        for (int r = 0; r < TPL_N; r++)
            for (int k = 0; k < TPL_N; k++) begin
                addr_q.push_back({1'b1, 7'(r), 7'(k)});
                tp = int'(tpl_mem[r*TPL_N + k][7:0]);
                et += longint'(tp * tp);
            end
        best = 64'h8000_0000_0000_0000;
        best_idx = 0;
        for (int tr = 0; tr < TILES; tr++)
            for (int tc = 0; tc < TILES; tc++) begin
                c = 0;
                ew = 0;
                for (int r = 0; r < TPL_N; r++)
                    for (int k = 0; k < TPL_N; k++) begin
                        rr = tr*TPL_N + r;
                        cc = tc*TPL_N + k;
                        addr_q.push_back({1'b0, 7'(rr), 7'(cc)});
                        tp = int'(tpl_mem[r*TPL_N + k][7:0]);
                        wp = int'(img_mem[rr*IMG_N + cc][7:0]);
                        c  += longint'(tp * wp);
                        ew += longint'(wp * wp);
                    end
                s = model_score(c, et, ew);
                if ($signed(s) > $signed(best)) begin
                    best = s;
                    best_idx = tr*TILES + tc;
                end
            end
        exp_q.push_back({9'(best_idx), best});
    endtask

    task automatic run_scenario(input string name);
        result_t     ex;
        int          wr_cnt = 0, bad = 0, hold_bad = 0;
        logic [31:0] wr_word = '0;
        logic [14:0] a;
        bit          prev_req = 0, done = 0;
        build_expect();
        ready_2_start = 1'b1;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge clk);
            if (set_done) begin
                done = 1;
            end else begin
                if (req && !rd_wr) begin
                    if (prev_req) bad++;
                    if (addr_q.size() == 0) bad++;
                    else begin
                        a = addr_q.pop_front();
                        if ({tem_win, row, col} !== a) bad++;
                    end
                    read_data = mem_word(tem_win, row, col);
                end
                if (req && rd_wr) begin
                    wr_cnt++;
                    wr_word = write_data;
                    if (row !== 7'd127 || col !== 7'd127 || tem_win !== 1'b1) bad++;
                end
                if (!(req && rd_wr) && (rd_wr !== 1'b0 || write_data !== 32'h0)) bad++;
                prev_req = req;
            end
        end
        ex = exp_q.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done: set_done=%0b not seen within %0d cycles", name, set_done, BUDGET);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s_protocol: %0d bus violations, required 0", name, bad);
        end
        checks++;
        if (addr_q.size() !== 0) begin
            errors++;
            $display("FAIL %s_reads: %0d expected reads not issued, required 0", name, addr_q.size());
        end
        checks++;
        if (wr_cnt !== 1) begin
            errors++;
            $display("FAIL %s_write_count: got %0d write cycles, required 1", name, wr_cnt);
        end
        checks++;
        if (wr_word !== {23'b0, ex.idx}) begin
            errors++;
            $display("FAIL %s_write_data: got %h, required %h", name, wr_word, {23'b0, ex.idx});
        end
        checks++;
        if (greatestWindowIndex !== ex.idx) begin
            errors++;
            $display("FAIL %s_index: got %0d, required %0d", name, greatestWindowIndex, ex.idx);
        end
        checks++;
        if (greatestNCCLog2 !== ex.score) begin
            errors++;
            $display("FAIL %s_score: got %h, required %h", name, greatestNCCLog2, ex.score);
        end
        for (int i = 0; i < 6; i++) begin
            ready_2_start = i[0];
            @(negedge clk);
            if (set_done !== 1'b1 || req !== 1'b0 || rd_wr !== 1'b0 || write_data !== 32'h0 ||
                greatestWindowIndex !== ex.idx || greatestNCCLog2 !== ex.score) hold_bad++;
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL %s_done_hold: %0d unstable DONE cycles, required 0", name, hold_bad);
        end
        ready_2_start = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({req, rd_wr, tem_win, set_done} !== 4'b0) begin
            errors++;
            $display("FAIL %s_ctrl: got req/rd_wr/tem_win/done=%b, required 0000", name,
                     {req, rd_wr, tem_win, set_done});
        end
        checks++;
        if ({write_data, row, col} !== 46'h0) begin
            errors++;
            $display("FAIL %s_bus: got wd=%h row=%0d col=%0d, required 0", name, write_data, row, col);
        end
        checks++;
        if (greatestNCCLog2 !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL %s_score: got %h, required 8000000000000000", name, greatestNCCLog2);
        end
        checks++;
        if (greatestWindowIndex !== 9'd0) begin
            errors++;
            $display("FAIL %s_index: got %0d, required 0", name, greatestWindowIndex);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        int  reqs = 0;
        bit  seen = 0;
        fill_tpl(32'd16);
        fill_img(32'd16);
        apply_reset();
        repeat (10) begin
            @(negedge clk);
            if (req) reqs++;
        end
        checks++;
        if (reqs !== 0) begin
            errors++;
            $display("FAIL start_idle: got %0d requests while not ready, required 0", reqs);
        end
        ready_2_start = 1'b1;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (req) seen = 1;
        end
        checks++;
        if (!seen || {tem_win, row, col, rd_wr} !== {1'b1, 7'd0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL start_first_req: seen=%0b tem_win=%b row=%0d col=%0d rd_wr=%b, required 1 1 0 0 0",
                     seen, tem_win, row, col, rd_wr);
        end
        ready_2_start = 1'b0;
    endtask

    task automatic test_flat();
        fill_tpl(32'd16);
        fill_img(32'd16);
        apply_reset();
        run_scenario("flat");
    endtask

    task automatic test_single_tile();
        fill_tpl(32'd1);
        fill_img(32'd0);
        for (int r = 0; r < TPL_N; r++)
            for (int k = 0; k < TPL_N; k++)
                img_mem[((37 / TILES)*TPL_N + r)*IMG_N + (37 % TILES)*TPL_N + k] = 32'd1;
        apply_reset();
        run_scenario("tile37");
    endtask

    task automatic test_high_bits();
        fill_tpl(32'hFFFF_FF05);
        fill_img(32'hFFFF_FF05);
        apply_reset();
        run_scenario("high_bits");
    endtask

    task automatic fill_random();
        logic [31:0] w;
        for (int i = 0; i < TPL_PIX; i++) begin
            w = $urandom;
            w[7:0] = 8'($urandom_range(1, 255));
            tpl_mem[i] = w;
        end
        for (int i = 0; i < IMG_N*IMG_N; i++) begin
            w = $urandom;
            w[7:0] = 8'($urandom_range(0, 255));
            img_mem[i] = w;
        end
    endtask

    task automatic test_random();
        fill_random();
        apply_reset();
        run_scenario("random");
    endtask

    task automatic test_midreset();
        int reqs = 0, late = 0;
        fill_random();
        apply_reset();
        ready_2_start = 1'b1;
        for (int cyc = 0; cyc < BUDGET && reqs < TPL_PIX*6; cyc++) begin
            @(negedge clk);
            if (req && !rd_wr) begin
                reqs++;
                read_data = mem_word(tem_win, row, col);
            end
        end
        checks++;
        if (reqs < TPL_PIX*6) begin
            errors++;
            $display("FAIL midreset_reach: got %0d reads, required %0d", reqs, TPL_PIX*6);
        end
        ready_2_start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (req) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL midreset_idle: got %0d requests after reset, required 0", late);
        end
        run_scenario("after_midreset");
    endtask

    initial begin
        test_reset();
        test_start();
        test_flat();
        test_single_tile();
        test_high_bits();
        test_random();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/user_fpga_test_core.md
USER_FPGA_TEST_CORE -- requirements
Module: user_fpga_test

Interface
REQ-001 SHALL have parameter TPL_N, default 8, meaning template/window side in pixels.
REQ-002 SHALL have parameter IMG_N, default 128, meaning image side in pixels (multiple of TPL_N, max 128).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ready_2_start  input  1  memory loaded, start permitted.
REQ-006 SHALL have port read_data  input  32  memory read word, pixel = bits [7:0], bits [31:8] ignored.
REQ-007 SHALL have port req  output  1  memory access request.
REQ-008 SHALL have port rd_wr  output  1  0 = read, 1 = write.
REQ-009 SHALL have port write_data  output  32  memory write word.
REQ-010 SHALL have port row  output  7  pixel row address.
REQ-011 SHALL have port col  output  7  pixel column address.
REQ-012 SHALL have port tem_win  output  1  1 = template memory, 0 = image memory.
REQ-013 SHALL have port set_done  output  1  run complete.
REQ-014 SHALL have port greatestNCCLog2  output  64  best score, signed fixed point, bit range [9:-54] (10 integer bits, 54 fraction bits).
REQ-015 SHALL have port greatestWindowIndex  output  9  index of best-scoring window.

Function
REQ-016 SHALL implement states IDLE, LOAD_TPL, LOAD_WIN, SCORE, WRITE, DONE.
REQ-017 IDLE SHALL move to LOAD_TPL on the first rising edge with ready_2_start=1.
REQ-018 Each read SHALL take 2 cycles: cycle k drives req=1, rd_wr=0, row, col, tem_win; read_data is sampled at the end of cycle k+1, with req=0 in cycle k+1.
REQ-019 LOAD_TPL SHALL read TPL_N x TPL_N template pixels (tem_win=1) in row-major order from (0,0), storing each pixel t.
REQ-020 LOAD_TPL SHALL accumulate Et = sum of t squared.
REQ-021 LOAD_WIN SHALL visit non-overlapping TPL_N x TPL_N tiles (tem_win=0) in tile-row-major order, with pixels row-major inside each tile.
REQ-022 Window index SHALL be (tile_row * IMG_N/TPL_N + tile_col), giving 0..255 at default parameters.
REQ-023 LOAD_WIN SHALL accumulate per tile C = sum of t*w and Ew = sum of w squared, both unsigned, at least 22 bits wide.
REQ-024 After the last pixel of each tile, the block SHALL spend one SCORE cycle computing S = 2*L(C) - L(Et) - L(Ew).
REQ-025 L(x) for x>0 with MSB position p SHALL be: integer part = p; fraction = bits below the MSB, left-aligned into 54 bits, truncated.
REQ-026 If C, Et or Ew is 0, S SHALL be 64'h8000_0000_0000_0000 (most negative).
REQ-027 If S is strictly greater (signed) than greatestNCCLog2, the block SHALL update greatestNCCLog2 and greatestWindowIndex; ties SHALL keep the earlier window.
REQ-028 After SCORE the block SHALL return to LOAD_WIN with C and Ew cleared, or go to WRITE after the last tile.
REQ-029 WRITE SHALL last one cycle with req=1, rd_wr=1, tem_win=1, row=127, col=127, write_data={23'b0, greatestWindowIndex}.
REQ-030 DONE SHALL hold set_done=1, req=0 and all results stable until reset; ready_2_start SHALL be ignored in DONE.
REQ-031 write_data SHALL be 0 and rd_wr SHALL be 0 outside WRITE.
REQ-032 row, col and tem_win SHALL hold their last value when req=0.

Reset
REQ-033 While rst_n=0: state IDLE; req, rd_wr, write_data, row, col, tem_win, set_done = 0; greatestNCCLog2 = 64'h8000_0000_0000_0000; greatestWindowIndex = 0; accumulators = 0.
REQ-034 Reset mid-operation SHALL abort immediately to IDLE and discard all partial results.

Structure
REQ-035 A shared package SHALL hold the state enum, the score type (signed 64-bit, [9:-54]), the SCORE_MIN constant, and the write-back address constants.
REQ-036 Sub-module log2_approx SHALL implement L(x) with a priority encoder and shifter; the rest SHALL be a single FSM/datapath module.

Verification
REQ-037 Reset: rst_n low -> all outputs 0, greatestNCCLog2 = 0x8000000000000000, req=0.
REQ-038 Start: ready_2_start=0 for 10 cycles -> no req; assert it -> first req with tem_win=1, row=0, col=0, rd_wr=0.
REQ-039 Flat memory (all pixels 16) -> every S=0, final greatestWindowIndex=0, greatestNCCLog2=0.
REQ-040 Template all 1, image 0 except tile 37 all 1 -> greatestWindowIndex=37, greatestNCCLog2=0.
REQ-041 read_data=0xFFFFFF05 everywhere -> pixels treated as 5, S=0, index 0.
REQ-042 Completion -> one write cycle with write_data=index, then set_done=1 held; rst_n pulse mid-LOAD_WIN -> IDLE, outputs back to reset values.
